robo_controller: RTL and testbench
==================================

ROBO_CONTROLLER -- requirements
Module: robo_controller

Interface
REQ-001 SHALL have parameter REMOVE_CYCLES, default 3, remover hold cycles per barrier level (matches map datapath counter).
REQ-002 SHALL have parameter MAX_RIGHT_TURNS, default 4, consecutive right turns without an advance before declaring stuck.
REQ-003 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level enable; 1 = run wall-follower.
REQ-006 SHALL have ports head_in, left_in, under_in, barrier_in  input  1 each  sensor levels from map datapath.
REQ-007 SHALL have ports avancar, girar, remover  output  1 each  registered commands to map datapath.
REQ-008 SHALL have ports busy, done, stuck  output  1 each  status.
REQ-009 SHALL have port move_count  output  8  count of advances since leaving IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, DECIDE, CMD, SETTLE, REMOVE, DONE, STUCK.
REQ-011 SHALL assert at most one of avancar/girar/remover in any cycle.
REQ-012 IDLE: outputs 0; start=1 -> DECIDE, clear move_count, turn_cnt, turned_left.
REQ-013 DECIDE evaluates in priority order: under_in=1 -> DONE; left_in=0 and turned_left=0 -> left turn; barrier_in=1 -> REMOVE; head_in=0 -> advance; else -> right turn.
REQ-014 Left turn: girar for 1 cycle in CMD, set turned_left=1.
REQ-015 Advance: avancar for 1 cycle in CMD, clear turned_left and turn_cnt, move_count+1 saturating at 255.
REQ-016 Right turn: girar for 3 consecutive CMD cycles, turn_cnt+1; turn_cnt reaching MAX_RIGHT_TURNS -> STUCK instead of SETTLE.
REQ-017 REMOVE: remover held exactly REMOVE_CYCLES cycles, then SETTLE.
REQ-018 Every CMD/REMOVE sequence SHALL be followed by exactly one SETTLE cycle (outputs 0) before DECIDE; sensors sampled only in DECIDE.
REQ-019 start deasserted mid-sequence: current CMD/REMOVE completes, SETTLE, then IDLE; never truncated.
REQ-020 DONE/STUCK: commands 0, done resp. stuck =1, held until start=0, then IDLE.
REQ-021 busy=1 in all states except IDLE, DONE, STUCK.
REQ-022 Latency start->first command: 2 cycles (IDLE->DECIDE->CMD).

Reset
REQ-023 Reset low SHALL immediately force IDLE, all outputs 0, move_count 0, internal counters/flags 0, regardless of state.
REQ-024 Deassertion SHALL take effect on the first rising clock edge after reset rises; no command issued on that edge.

Configuration
REQ-025 Macro ROBO_BARRIER_REMOVE_EN defined: REMOVE path per REQ-013/017.
REQ-026 Macro undefined: barrier_in=1 SHALL be treated as head_in=1 (right turn), remover tied 0, REMOVE state absent.

Structure
REQ-027 State encoding, REMOVE_CYCLES/MAX_RIGHT_TURNS defaults and right-turn pulse count (3) SHALL live in shared include robo_defs.vh, shared with map datapath.
REQ-028 Pulse timing (hold-N-cycles counter for girar/remover) SHALL be sub-module robo_pulse_gen; FSM instantiates it once.

Verification
REQ-029 start=1, left=1, head=0, others 0 -> avancar pulse at cycle 2, SETTLE, avancar again at cycle 5; move_count 1 then 2.
REQ-030 left=0 from start -> one girar pulse, then with left held 0 -> avancar (no second left turn).
REQ-031 head=1, left=1 held -> 3 girar cycles per right turn; after 4th right turn stuck=1, busy=0, no further commands.
REQ-032 barrier_in=1, head=0, left=1 (macro defined) -> remover high exactly 3 cycles, 1 idle, re-decide; macro undefined -> 3 girar cycles, remover never 1.
REQ-033 under_in=1 at DECIDE -> done=1 next cycle; start=0 -> IDLE, done=0.
REQ-034 reset low during 2nd girar of right turn -> all outputs 0 asynchronously; after release and start=1, first command at cycle 2.

Source files
------------

// File: rtl/robo_controller_pkg.sv
// Shared encodings, defaults and helpers for the wall-following robot controller.
package robo_controller_pkg;

  localparam int unsigned REMOVE_CYCLES_DEF   = 3;
  localparam int unsigned MAX_RIGHT_TURNS_DEF = 4;
  localparam int unsigned RIGHT_TURN_PULSES   = 3;
  localparam int unsigned PULSE_W             = 8;
  localparam int unsigned COUNT_W             = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECIDE = 3'd1,
    ST_CMD    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_REMOVE = 3'd4,
    ST_DONE   = 3'd5,
    ST_STUCK  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_ADV    = 2'd1,
    CMD_TURN   = 2'd2,
    CMD_REMOVE = 2'd3
  } cmd_t;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : COUNT_W'(v + COUNT_W'(1));
  endfunction

endpackage

// File: rtl/robo_controller_pulse_gen.sv
// Holds one command line high for a programmed number of cycles; last_c flags
// the final cycle so the controller can leave its command state in step.
module robo_pulse_gen
  import robo_controller_pkg::*;
#(
  parameter bit REMOVE_EN = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               trigger,
  input  cmd_t               sel,
  input  logic [PULSE_W-1:0] len,
  output logic               avancar,
  output logic               girar,
  output logic               remover,
  output logic               last_c
);

  logic [PULSE_W-1:0] cnt_q;
  logic               active_c;

  assign active_c = avancar | girar | remover;
  assign last_c   = active_c && (cnt_q == '0);

  // cnt_q holds the number of cycles still to run after the current one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      avancar <= 1'b0;
      girar   <= 1'b0;
      remover <= 1'b0;
      cnt_q   <= '0;
    end else if (trigger) begin
      avancar <= (sel == CMD_ADV);
      girar   <= (sel == CMD_TURN);
      remover <= REMOVE_EN && (sel == CMD_REMOVE);
      cnt_q   <= len - PULSE_W'(1);
    end else if (active_c) begin
      if (cnt_q == '0) begin
        avancar <= 1'b0;
        girar   <= 1'b0;
        remover <= 1'b0;
      end else begin
        cnt_q <= cnt_q - PULSE_W'(1);
      end
    end
  end

endmodule

// File: rtl/robo_controller.sv
// Wall-following robot controller issuing advance/turn/remove commands.
// Define ROBO_BARRIER_REMOVE_EN to enable the barrier-removal path.
module robo_controller
  import robo_controller_pkg::*;
#(
  parameter int unsigned REMOVE_CYCLES   = REMOVE_CYCLES_DEF,
  parameter int unsigned MAX_RIGHT_TURNS = MAX_RIGHT_TURNS_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               head_in,
  input  logic               left_in,
  input  logic               under_in,
  input  logic               barrier_in,
  output logic               avancar,
  output logic               girar,
  output logic               remover,
  output logic               busy,
  output logic               done,
  output logic               stuck,
  output logic [COUNT_W-1:0] move_count
);

`ifdef ROBO_BARRIER_REMOVE_EN
  localparam bit REMOVE_EN = 1'b1;
`else
  localparam bit REMOVE_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] move_d;
  logic [COUNT_W-1:0] turn_cnt_q, turn_cnt_d;
  logic               turned_left_q, turned_left_d;
  logic               pg_trigger_c;
  cmd_t               pg_sel_c;
  logic [PULSE_W-1:0] pg_len_c;
  logic               pg_last_c;

  robo_pulse_gen #(
    .REMOVE_EN (REMOVE_EN)
  ) u_pulse_gen (
    .clock   (clock),
    .reset   (reset),
    .trigger (pg_trigger_c),
    .sel     (pg_sel_c),
    .len     (pg_len_c),
    .avancar (avancar),
    .girar   (girar),
    .remover (remover),
    .last_c  (pg_last_c)
  );

  // Next-state and command selection; sensors only matter in DECIDE.
  always_comb begin
    state_d       = state_q;
    move_d        = move_count;
    turn_cnt_d    = turn_cnt_q;
    turned_left_d = turned_left_q;
    pg_trigger_c  = 1'b0;
    pg_sel_c      = CMD_NONE;
    pg_len_c      = PULSE_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_DECIDE;
          move_d        = '0;
          turn_cnt_d    = '0;
          turned_left_d = 1'b0;
        end
      end
      ST_DECIDE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (under_in) begin
          state_d = ST_DONE;
        end else if (!left_in && !turned_left_q) begin
          pg_trigger_c  = 1'b1;
          pg_sel_c      = CMD_TURN;
          turned_left_d = 1'b1;
          state_d       = ST_CMD;
        end else if (REMOVE_EN && barrier_in) begin
          pg_trigger_c = 1'b1;
          pg_sel_c     = CMD_REMOVE;
          pg_len_c     = PULSE_W'(REMOVE_CYCLES);
          state_d      = ST_REMOVE;
        end else if (!head_in && !barrier_in) begin
          pg_trigger_c  = 1'b1;
          pg_sel_c      = CMD_ADV;
          turned_left_d = 1'b0;
          turn_cnt_d    = '0;
          move_d        = sat_inc(move_count);
          state_d       = ST_CMD;
        end else begin
          // Blocked ahead (an unremovable barrier counts as a wall): turn right.
          pg_trigger_c = 1'b1;
          pg_sel_c     = CMD_TURN;
          pg_len_c     = PULSE_W'(RIGHT_TURN_PULSES);
          turn_cnt_d   = turn_cnt_q + COUNT_W'(1);
          state_d      = ST_CMD;
        end
      end
      ST_CMD: begin
        if (pg_last_c) begin
          state_d = (turn_cnt_q == COUNT_W'(MAX_RIGHT_TURNS)) ? ST_STUCK : ST_SETTLE;
        end
      end
`ifdef ROBO_BARRIER_REMOVE_EN
      ST_REMOVE: begin
        if (pg_last_c) state_d = ST_SETTLE;
      end
`endif
      ST_SETTLE: state_d = start ? ST_DECIDE : ST_IDLE;
      ST_DONE, ST_STUCK: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      move_count    <= '0;
      turn_cnt_q    <= '0;
      turned_left_q <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      stuck         <= 1'b0;
    end else begin
      state_q       <= state_d;
      move_count    <= move_d;
      turn_cnt_q    <= turn_cnt_d;
      turned_left_q <= turned_left_d;
      busy          <= !(state_d inside {ST_IDLE, ST_DONE, ST_STUCK});
      done          <= (state_d == ST_DONE);
      stuck         <= (state_d == ST_STUCK);
    end
  end

endmodule

// File: tb/tb_robo_controller.sv
// Bench for robo_controller: directed scenarios plus random sensors against a
// schedule-based model (each decision expands into a queue of expected cycles).
module tb_robo_controller;

  localparam int unsigned RC   = 3;
  localparam int unsigned MAXR = 4;

  logic       clock, reset, start, head_in, left_in, under_in, barrier_in;
  logic       avancar, girar, remover, busy, done, stuck;
  logic [7:0] move_count;

  robo_controller #(
    .REMOVE_CYCLES   (RC),
    .MAX_RIGHT_TURNS (MAXR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .head_in    (head_in),
    .left_in    (left_in),
    .under_in   (under_in),
    .barrier_in (barrier_in),
    .avancar    (avancar),
    .girar      (girar),
    .remover    (remover),
    .busy       (busy),
    .done       (done),
    .stuck      (stuck),
    .move_count (move_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {P_IDLE, P_DECIDE, P_ADV, P_TURN, P_REM, P_SETTLE, P_DONE, P_STUCK} phase_e;
  phase_e cur;
  phase_e plan[$];
  int     mc, tc;
  bit     tl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {avancar, girar, remover, busy, done, stuck, move_count};
  endfunction

  function automatic logic [13:0] model_vec();
    logic b;
    b = !(cur == P_IDLE || cur == P_DONE || cur == P_STUCK);
    return {cur == P_ADV, cur == P_TURN, cur == P_REM, b,
            cur == P_DONE, cur == P_STUCK, 8'(mc)};
  endfunction

  task automatic model_reset();
    cur = P_IDLE;
    plan.delete();
    mc = 0;
    tc = 0;
    tl = 0;
  endtask

  // Expand one decision into the list of cycles it will occupy.
  task automatic model_decide();
    bit rem_en;
`ifdef ROBO_BARRIER_REMOVE_EN
    rem_en = 1;
`else
    rem_en = 0;
`endif
    plan.delete();
    if (under_in) begin
      plan.push_back(P_DONE);
    end else if (!left_in && !tl) begin
      tl = 1;
      plan.push_back(P_TURN);
      plan.push_back(P_SETTLE);
    end else if (barrier_in && rem_en) begin
      repeat (RC) plan.push_back(P_REM);
      plan.push_back(P_SETTLE);
    end else if (!head_in && !barrier_in) begin
      tl = 0;
      tc = 0;
      if (mc < 255) mc++;
      plan.push_back(P_ADV);
      plan.push_back(P_SETTLE);
    end else begin
      tc++;
      repeat (3) plan.push_back(P_TURN);
      plan.push_back(tc == MAXR ? P_STUCK : P_SETTLE);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    case (cur)
      P_IDLE: if (start) begin
        cur = P_DECIDE; mc = 0; tc = 0; tl = 0;
      end
      P_DECIDE: begin
        if (!start) cur = P_IDLE;
        else begin
          model_decide();
          cur = plan.pop_front();
        end
      end
      P_SETTLE: cur = start ? P_DECIDE : P_IDLE;
      P_DONE, P_STUCK: if (!start) cur = P_IDLE;
      default: cur = (plan.size() > 0) ? plan.pop_front() : P_IDLE;
    endcase
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_eq("cycle", 32'(dut_vec()), 32'(model_vec()));
    check_eq("onehot", 32'($countones({avancar, girar, remover}) <= 1), 32'd1);
  endtask

  task automatic set_in(input logic s, input logic h, input logic l, input logic u, input logic b);
    start = s; head_in = h; left_in = l; under_in = u; barrier_in = b;
  endtask

  task automatic go_idle();
    start = 1'b0;
    repeat (8) step();
    check_eq("idle", 32'({busy, done, stuck}), 32'd0);
  endtask

  initial begin
    int gcount, rcount, quiet, first;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_state", 32'(dut_vec()), 32'd0);
    reset = 1'b1;

    // Straight corridor: advance at cycle 2 and 5.
    set_in(1, 0, 1, 0, 0);
    step(); step();
    check_eq("adv_c2", 32'({avancar, move_count}), 32'h101);
    step(); step(); step();
    check_eq("adv_c5", 32'({avancar, move_count}), 32'h102);

    // Open left: one left turn, then advance instead of a second left turn.
    go_idle();
    set_in(1, 0, 0, 0, 0);
    step(); step();
    check_eq("left_turn", 32'(girar), 32'd1);
    step(); step(); step();
    check_eq("no_second_left", 32'(avancar), 32'd1);

    // Boxed in: four right turns of three girar cycles each, then stuck.
    go_idle();
    set_in(1, 1, 1, 0, 0);
    gcount = 0;
    repeat (25) begin step(); gcount += int'(girar); end
    check_eq("girar_total", 32'(gcount), 32'd12);
    check_eq("stuck_status", 32'({stuck, busy}), 32'b10);
    quiet = 0;
    repeat (5) begin step(); quiet += int'(avancar | girar | remover); end
    check_eq("stuck_quiet", 32'(quiet), 32'd0);

    // Barrier ahead.
    go_idle();
    set_in(1, 0, 1, 0, 1);
    gcount = 0; rcount = 0;
    repeat (6) begin step(); gcount += int'(girar); rcount += int'(remover); end
`ifdef ROBO_BARRIER_REMOVE_EN
    check_eq("barrier_girar", 32'(gcount), 32'd0);
    check_eq("barrier_remover", 32'(rcount), 32'd3);
`else
    check_eq("barrier_girar", 32'(gcount), 32'd3);
    check_eq("barrier_remover", 32'(rcount), 32'd0);
`endif

    // Goal reached.
    go_idle();
    set_in(1, 0, 1, 1, 0);
    step(); step();
    check_eq("done_set", 32'({done, busy}), 32'b10);
    start = 1'b0;
    step();
    check_eq("done_clear", 32'(done), 32'd0);

    // move_count saturation.
    go_idle();
    set_in(1, 0, 1, 0, 0);
    repeat (800) step();
    check_eq("mc_sat", 32'(move_count), 32'd255);

    // Random sensors with occasional start drops and resets.
    go_idle();
    repeat (3000) begin
      start      = ($urandom_range(0, 29) != 0);
      head_in    = 1'($urandom_range(0, 1));
      left_in    = ($urandom_range(0, 3) != 0);
      under_in   = ($urandom_range(0, 49) == 0);
      barrier_in = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rnd_async_reset", 32'(dut_vec()), 32'd0);
        step();
        reset = 1'b1;
      end
      step();
    end

    // Reset during the second girar cycle of a right turn, then restart.
    go_idle();
    set_in(1, 1, 1, 0, 0);
    step(); step();
    check_eq("rt_girar1", 32'(girar), 32'd1);
    step();
    check_eq("rt_girar2", 32'(girar), 32'd1);
    #1 reset = 1'b0;
    model_reset();
    #1;
    check_eq("async_reset", 32'(dut_vec()), 32'd0);
    step(); step();
    reset = 1'b1;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (first == 0 && (avancar | girar | remover)) first = i;
    end
    check_eq("restart_latency", 32'(first), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
